// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned RV32M multiply/divide sequencer.
// It time-shares the execute-stage 32-bit ALU for every 32-bit add/subtract,
// doing one shift-add (MUL/MULHU) or shift-subtract (DIVU/REMU) step per cycle.
// Shifts, the multiply carry and the divide compare are done locally.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       request handshake; req_ready is high only in IDLE
//   req_op, req_a, req_b      0=MUL 1=MULHU 2=DIVU 3=REMU, operands
//   kill                      abort in-flight op (pipeline flush)
//   resp_valid/resp_ready     response handshake
//   resp_data                 registered result
//   busy                      ALU is granted to this block while high
//   alu_a, alu_b, alu_sel     ALU operand/select drive
//   alu_out                   ALU result, combinational, same cycle
//
// state | meaning
// IDLE  | waiting for a request, ALU outputs parked at ADD 0+0
// ITER  | one shift-add / shift-subtract step per cycle, 32 steps
// DONE  | result held on resp_data until the consumer takes it

`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module alu_muldiv_seq #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_DIV_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    // hi: acc_hi (multiply) or rem (divide)
    // lo: acc_lo (multiply) or quo (divide)
    // opb: mcand (multiply) or dvsr (divide)
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;

    logic [WIDTH:0]     sh;
    logic               carry;
    logic               ge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        resp_data_d = resp_data_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = `ALU_ADD;
        sh          = '0;
        carry       = 1'b0;
        ge          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !kill) begin
                    // Both op families start with hi=0, lo=a, opb=b.
                    op_d  = req_op;
                    cnt_d = '0;
                    hi_d  = '0;
                    lo_d  = req_a;
                    opb_d = req_b;
                    if (ZERO_DIV_FAST && req_op[1] && (req_b == '0)) begin
                        state_d     = S_DONE;
                        resp_data_d = req_op[0] ? req_a : '1;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (op_q[1]) begin
                    // Restoring division; when sh[WIDTH] is set the
                    // modulo-2^WIDTH wrap of the subtract is the right remainder.
                    sh      = {hi_q, lo_q[WIDTH-1]};
                    alu_a   = sh[WIDTH-1:0];
                    alu_b   = opb_q;
                    alu_sel = `ALU_SUB;
                    ge      = sh[WIDTH] | (sh[WIDTH-1:0] >= opb_q);
                    hi_d    = ge ? alu_out : sh[WIDTH-1:0];
                    lo_d    = {lo_q[WIDTH-2:0], ge};
                end else begin
                    alu_a   = hi_q;
                    alu_b   = lo_q[0] ? opb_q : '0;
                    alu_sel = `ALU_ADD;
                    carry   = (alu_out < hi_q);
                    hi_d    = {carry, alu_out[WIDTH-1:1]};
                    lo_d    = {alu_out[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    // MUL/DIVU take lo (acc_lo/quo), MULHU/REMU take hi.
                    resp_data_d = op_q[0] ? hi_d : lo_d;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wins over any step or handshake in progress.
        if (kill && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            resp_data_d = resp_data_q;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif

module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the execute-stage ALU.
    assign alu_out = (alu_sel == `ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    alu_muldiv_seq #(.WIDTH(32), .ZERO_DIV_FAST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts edges until resp_valid.
    task automatic wait_resp(input string tag, input logic [1:0] op, input int exp_lat);
        int lat;
        int sel_bad;
        logic [3:0] exp_sel;
        exp_sel = op[1] ? `ALU_SUB : `ALU_ADD;
        lat     = 1;
        sel_bad = 0;
        while (!resp_valid && lat < 60) begin
            if (alu_sel !== exp_sel) sel_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_alu_sel_bad_cycles"}, sel_bad, 0);
        check({tag, "_req_ready_in_done"}, {31'b0, req_ready}, 32'd0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_resp_valid_dropped"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_idle_after_consume"}, {30'b0, busy, req_ready}, 32'b01);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        start_op(op, a, b);
        wait_resp(tag, op, exp_lat);
        check({tag, "_data"}, resp_data, exp);
        consume(tag);
    endtask

    task automatic expect_no_resp(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check({tag, "_spurious_resp"}, seen, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data,           32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_alu_sel",    {28'b0, alu_sel},    {28'b0, `ALU_ADD});
        check("rst_alu_a",      alu_a,               32'd0);
        check("rst_alu_b",      alu_b,               32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6",       2'd0, 32'd7,          32'd6,          32'd42,         33);
        run_op("mulhu_ffff",    2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33);
        run_op("mul_ffff",      2'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33);
        run_op("divu_100_7",    2'd2, 32'd100,        32'd7,          32'd14,         33);
        run_op("remu_100_7",    2'd3, 32'd100,        32'd7,          32'd2,          33);
        run_op("divu_8000_3",   2'd2, 32'h80000000,   32'd3,          32'h2AAAAAAA,   33);
        run_op("remu_sh32",     2'd3, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE,   33);
        run_op("divu_by_zero",  2'd2, 32'd5,          32'd0,          32'hFFFFFFFF,   1);
        run_op("remu_by_zero",  2'd3, 32'd5,          32'd0,          32'd5,          1);

        // Backpressure: result must hold steady for 10 cycles.
        start_op(2'd2, 32'd1000, 32'd10);
        wait_resp("bp_divu", 2'd2, 33);
        check("bp_data", resp_data, 32'd100);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_hold_data",  resp_data,           32'd100);
            check("bp_hold_ready", {31'b0, req_ready},  32'd0);
        end
        consume("bp");
        run_op("after_bp_remu", 2'd3, 32'd1000, 32'd7, 32'd6, 33);

        // Kill during ITER cycle 10.
        start_op(2'd0, 32'h12345678, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy",       {31'b0, busy},       32'd0);
        check("kill_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("kill_req_ready",  {31'b0, req_ready},  32'd1);
        expect_no_resp("kill");

        // Kill in IDLE blocks a simultaneous request.
        @(negedge clk);
        req_op    = 2'd0;
        req_a     = 32'd9;
        req_b     = 32'd9;
        req_valid = 1'b1;
        kill      = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        check("kill_idle_no_accept", {31'b0, busy}, 32'd0);
        run_op("mul_3x5_after_kill", 2'd0, 32'd3, 32'd5, 32'd15, 33);

        // Async reset at ITER cycle 20.
        start_op(2'd2, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy",       {31'b0, busy},       32'd0);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_resp_data",  resp_data,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_resp("rst_mid");
        run_op("mul_3x5_after_rst", 2'd0, 32'd3, 32'd5, 32'd15, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
